// File: rtl/r5p_soc_periph_bridge.sv
// System-bus (DLY=1) to peripheral (DLY=0) bridge with address decode, unmapped-address and ready-timeout errors.
// Zero-wait latency: request cycle 0 -> per_vld/sub_rdy cycle 1 -> sub_rdt/sub_err cycle 2; sub_rdy follows per_rdy of the selected port.
module r5p_soc_periph_bridge #(
    parameter int unsigned PN   = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned PSH  = 6,
    parameter logic [AW-1:0] BASE = 32'h0020_0000,
    parameter logic [AW-1:0] BMSK = 32'hfff0_0000,
    parameter int unsigned TMO  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sub_vld,
    input  logic               sub_wen,
    input  logic [AW-1:0]      sub_adr,
    input  logic [DW/8-1:0]    sub_ben,
    input  logic [DW-1:0]      sub_wdt,
    output logic [DW-1:0]      sub_rdt,
    output logic               sub_err,
    output logic               sub_rdy,
    output logic [PN-1:0]      per_vld,
    output logic               per_wen,
    output logic [AW-1:0]      per_adr,
    output logic [DW/8-1:0]    per_ben,
    output logic [DW-1:0]      per_wdt,
    input  logic [PN*DW-1:0]   per_rdt,
    input  logic [PN-1:0]      per_err,
    input  logic [PN-1:0]      per_rdy,
    output logic               err_vld,
    output logic               err_tmo,
    output logic [AW-1:0]      err_adr,
    input  logic               err_clr
);

    localparam int unsigned IW = (PN > 1) ? $clog2(PN) : 1;
    localparam int unsigned CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERROR
    } state_t;

    state_t          state;
    logic [IW-1:0]   req_idx;
    logic [CW-1:0]   tmo_cnt;

    logic [IW-1:0]   sub_idx;
    logic            mapped;
    logic [DW-1:0]   sel_rdt;
    logic            sel_err;
    logic            sel_rdy;
    logic            tmo_hit;

    assign sub_idx = sub_adr[PSH +: IW];
    assign mapped  = ((sub_adr & BMSK) == (BASE & BMSK)) && (32'(sub_idx) < PN);

    // Response mux over the registered index; out-of-range indices never reach ACCESS.
    always_comb begin
        sel_rdt = '0;
        sel_err = 1'b0;
        sel_rdy = 1'b0;
        for (int i = 0; i < int'(PN); i++) begin
            if (req_idx == IW'(i)) begin
                sel_rdt = per_rdt[i*DW +: DW];
                sel_err = per_err[i];
                sel_rdy = per_rdy[i];
            end
        end
    end

    assign tmo_hit = (TMO != 0) && !sel_rdy && (tmo_cnt == CW'(TMO - 1));

    always_comb begin
        sub_rdy = 1'b0;
        case (state)
            ACCESS:  sub_rdy = sel_rdy | tmo_hit;
            ERROR:   sub_rdy = 1'b1;
            default: sub_rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            req_idx <= '0;
            tmo_cnt <= '0;
            per_vld <= '0;
            per_wen <= 1'b0;
            per_adr <= '0;
            per_ben <= '0;
            per_wdt <= '0;
            sub_rdt <= '0;
            sub_err <= 1'b0;
            err_vld <= 1'b0;
            err_tmo <= 1'b0;
            err_adr <= '0;
        end else begin
            // A capture later in this block overrides the clear.
            if (err_clr) begin
                err_vld <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sub_vld) begin
                        per_wen <= sub_wen;
                        per_adr <= sub_adr;
                        per_ben <= sub_ben;
                        per_wdt <= sub_wdt;
                        req_idx <= sub_idx;
                        tmo_cnt <= '0;
                        if (mapped) begin
                            per_vld <= PN'(1) << sub_idx;
                            state   <= ACCESS;
                        end else begin
                            state   <= ERROR;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_rdy) begin
                        sub_rdt <= sel_rdt;
                        sub_err <= sel_err;
                        per_vld <= '0;
                        state   <= IDLE;
                    end else if (tmo_hit) begin
                        sub_rdt <= '0;
                        sub_err <= 1'b1;
                        err_vld <= 1'b1;
                        err_tmo <= 1'b1;
                        err_adr <= per_adr;
                        per_vld <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                ERROR: begin
                    sub_rdt <= '0;
                    sub_err <= 1'b1;
                    err_vld <= 1'b1;
                    err_tmo <= 1'b0;
                    err_adr <= per_adr;
                    state   <= IDLE;
                end
                default: begin
                    per_vld <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r5p_soc_periph_bridge.sv
// Directed bench: expected responses queued at request time, compared by a response monitor.
module tb_r5p_soc_periph_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         sub_vld, sub_wen, err_clr;
    logic [31:0]  sub_adr, sub_wdt;
    logic [3:0]   sub_ben;
    logic [31:0]  sub_rdt;
    logic         sub_err, sub_rdy;
    logic [3:0]   per_vld;
    logic         per_wen;
    logic [31:0]  per_adr, per_wdt;
    logic [3:0]   per_ben;
    logic [127:0] per_rdt;
    logic [3:0]   per_err, per_rdy;
    logic         err_vld, err_tmo;
    logic [31:0]  err_adr;

    logic [31:0]  d3_rdt, d3_per_adr, d3_per_wdt, d3_err_adr;
    logic         d3_err, d3_rdy, d3_per_wen, d3_err_vld, d3_err_tmo;
    logic [2:0]   d3_per_vld;
    logic [3:0]   d3_per_ben;

    typedef struct packed {
        logic [31:0] rdt;
        logic        err;
    } rsp_t;

    rsp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    bit   pend = 1'b0;

    always #5 clk = ~clk;

    r5p_soc_periph_bridge u_dut (
        .clk(clk), .rst(rst),
        .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt),
        .sub_rdt(sub_rdt), .sub_err(sub_err), .sub_rdy(sub_rdy),
        .per_vld(per_vld), .per_wen(per_wen), .per_adr(per_adr), .per_ben(per_ben), .per_wdt(per_wdt),
        .per_rdt(per_rdt), .per_err(per_err), .per_rdy(per_rdy),
        .err_vld(err_vld), .err_tmo(err_tmo), .err_adr(err_adr), .err_clr(err_clr)
    );

    r5p_soc_periph_bridge #(.PN(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt),
        .sub_rdt(d3_rdt), .sub_err(d3_err), .sub_rdy(d3_rdy),
        .per_vld(d3_per_vld), .per_wen(d3_per_wen), .per_adr(d3_per_adr), .per_ben(d3_per_ben), .per_wdt(d3_per_wdt),
        .per_rdt(per_rdt[95:0]), .per_err(per_err[2:0]), .per_rdy(per_rdy[2:0]),
        .err_vld(d3_err_vld), .err_tmo(d3_err_tmo), .err_adr(d3_err_adr), .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] rdt, input logic err);
        rsp_t r;
        r.rdt = rdt;
        r.err = err;
        sbq.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wen, input logic [31:0] adr, input logic [3:0] ben, input logic [31:0] wdt);
        sub_vld = 1'b1;
        sub_wen = wen;
        sub_adr = adr;
        sub_ben = ben;
        sub_wdt = wdt;
    endtask

    // Response is valid the cycle after a sub handshake.
    always @(negedge clk) begin
        if (pend) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got rdt 0x%08h err %0b with empty queue", sub_rdt, sub_err);
            end else begin
                rsp_t e;
                e = sbq.pop_front();
                chk("rsp_rdt", sub_rdt, e.rdt);
                chk("rsp_err", {31'b0, sub_err}, {31'b0, e.err});
            end
        end
        pend = rst && sub_vld && sub_rdy;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sub_vld = 1'b0; sub_wen = 1'b0; sub_adr = '0; sub_ben = '0; sub_wdt = '0;
        err_clr = 1'b0;
        per_rdt = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        per_err = '0;
        per_rdy = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_per_vld", {28'b0, per_vld}, 32'h0);
        chk("rst_sub_rdy", {31'b0, sub_rdy}, 32'h0);
        chk("rst_sub_rdt", sub_rdt, 32'h0);
        chk("rst_err_vld", {31'b0, err_vld}, 32'h0);
        chk("rst_err_adr", err_adr, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Zero-wait read to port 1.
        req(1'b0, 32'h0020_0044, 4'hF, 32'h0);
        per_rdy = 4'b0010;
        expect_rsp(32'hCAFE_0001, 1'b0);
        @(negedge clk);
        chk("rd_c0_rdy", {31'b0, sub_rdy}, 32'h0);
        chk("rd_c0_per_vld", {28'b0, per_vld}, 32'h0);
        tick();
        @(negedge clk);
        chk("rd_c1_per_vld", {28'b0, per_vld}, 32'h2);
        chk("rd_c1_rdy", {31'b0, sub_rdy}, 32'h1);
        chk("rd_c1_per_adr", per_adr, 32'h0020_0044);
        tick();
        sub_vld = 1'b0;
        per_rdy = '0;
        @(negedge clk);
        chk("rd_c2_per_vld", {28'b0, per_vld}, 32'h0);
        tick();

        // Write to port 3 with three wait cycles.
        req(1'b1, 32'h0020_00C0, 4'b0011, 32'h1234_5678);
        expect_rsp(32'hCAFE_0003, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            per_rdy = (c == 4) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            chk("wr_per_vld", {28'b0, per_vld}, 32'h8);
            chk("wr_per_wdt", per_wdt, 32'h1234_5678);
            chk("wr_per_ben", {28'b0, per_ben}, 32'h3);
            chk("wr_per_wen", {31'b0, per_wen}, 32'h1);
            chk("wr_sub_rdy", {31'b0, sub_rdy}, (c == 4) ? 32'h1 : 32'h0);
        end
        tick();
        sub_vld = 1'b0;
        per_rdy = '0;
        @(negedge clk);
        chk("wr_end_per_vld", {28'b0, per_vld}, 32'h0);
        tick();
        tick();
        tick();

        // Address outside the peripheral region.
        req(1'b0, 32'h0030_0000, 4'hF, 32'h0);
        expect_rsp(32'h0, 1'b1);
        tick();
        @(negedge clk);
        chk("um_per_vld", {28'b0, per_vld}, 32'h0);
        chk("um_rdy", {31'b0, sub_rdy}, 32'h1);
        tick();
        sub_vld = 1'b0;
        @(negedge clk);
        chk("um_err_vld", {31'b0, err_vld}, 32'h1);
        chk("um_err_tmo", {31'b0, err_tmo}, 32'h0);
        chk("um_err_adr", err_adr, 32'h0030_0000);
        chk("um_d3_err_adr", d3_err_adr, 32'h0030_0000);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_err_vld", {31'b0, err_vld}, 32'h0);
        chk("clr_d3_err_vld", {31'b0, d3_err_vld}, 32'h0);
        chk("clr_err_adr_hold", err_adr, 32'h0030_0000);
        tick();

        // Index 3 with PN=3 is unmapped; err_clr in the capture cycle loses.
        req(1'b0, 32'h0020_00C0, 4'hF, 32'h0);
        per_rdy = 4'b1000;
        expect_rsp(32'hCAFE_0003, 1'b0);
        tick();
        err_clr = 1'b1;
        @(negedge clk);
        chk("d3_per_vld", {29'b0, d3_per_vld}, 32'h0);
        chk("d3_rdy", {31'b0, d3_rdy}, 32'h1);
        chk("pn4_per_vld", {28'b0, per_vld}, 32'h8);
        tick();
        err_clr = 1'b0;
        sub_vld = 1'b0;
        per_rdy = '0;
        @(negedge clk);
        chk("d3_sub_err", {31'b0, d3_err}, 32'h1);
        chk("d3_sub_rdt", d3_rdt, 32'h0);
        chk("d3_err_vld", {31'b0, d3_err_vld}, 32'h1);
        chk("d3_err_tmo", {31'b0, d3_err_tmo}, 32'h0);
        chk("d3_err_adr", d3_err_adr, 32'h0020_00C0);
        chk("pn4_err_vld_clr", {31'b0, err_vld}, 32'h0);
        tick();
        tick();

        // Peripheral error passes through without a capture.
        req(1'b0, 32'h0020_0048, 4'hF, 32'h0);
        per_rdy = 4'b0010;
        per_err = 4'b0010;
        expect_rsp(32'hCAFE_0001, 1'b1);
        tick();
        tick();
        sub_vld = 1'b0;
        per_rdy = '0;
        per_err = '0;
        @(negedge clk);
        chk("perr_err_vld", {31'b0, err_vld}, 32'h0);
        tick();

        // Ready timeout on port 0.
        req(1'b0, 32'h0020_0000, 4'hF, 32'h0);
        expect_rsp(32'h0, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            @(negedge clk);
            chk("tmo_per_vld", {28'b0, per_vld}, 32'h1);
            chk("tmo_sub_rdy", {31'b0, sub_rdy}, (c == 16) ? 32'h1 : 32'h0);
        end
        tick();
        sub_vld = 1'b0;
        @(negedge clk);
        chk("tmo_end_per_vld", {28'b0, per_vld}, 32'h0);
        chk("tmo_err_vld", {31'b0, err_vld}, 32'h1);
        chk("tmo_err_tmo", {31'b0, err_tmo}, 32'h1);
        chk("tmo_err_adr", err_adr, 32'h0020_0000);
        for (int c = 0; c < 2; c++) begin
            tick();
            per_rdy = 4'b1111;
            @(negedge clk);
            chk("late_rdy_sub_rdy", {31'b0, sub_rdy}, 32'h0);
            chk("late_rdy_per_vld", {28'b0, per_vld}, 32'h0);
        end
        tick();
        per_rdy = '0;
        chk("late_rdy_queue", sbq.size(), 32'h0);
        tick();

        // Back-to-back zero-wait reads to ports 0 and 2.
        per_rdy = 4'b0101;
        req(1'b0, 32'h0020_0000, 4'hF, 32'h0);
        expect_rsp(32'hCAFE_0000, 1'b0);
        expect_rsp(32'hCAFE_0002, 1'b0);
        tick();
        @(negedge clk);
        chk("b2b_c1_per_vld", {28'b0, per_vld}, 32'h1);
        chk("b2b_c1_rdy", {31'b0, sub_rdy}, 32'h1);
        tick();
        req(1'b0, 32'h0020_0080, 4'hF, 32'h0);
        @(negedge clk);
        chk("b2b_c2_per_vld", {28'b0, per_vld}, 32'h0);
        chk("b2b_c2_rdy", {31'b0, sub_rdy}, 32'h0);
        tick();
        @(negedge clk);
        chk("b2b_c3_per_vld", {28'b0, per_vld}, 32'h4);
        chk("b2b_c3_rdy", {31'b0, sub_rdy}, 32'h1);
        tick();
        sub_vld = 1'b0;
        per_rdy = '0;
        tick();
        tick();
        @(negedge clk);
        chk("rsp_hold_rdt", sub_rdt, 32'hCAFE_0002);
        tick();

        // Reset during a stalled access.
        req(1'b0, 32'h0020_0040, 4'hF, 32'h0);
        tick();
        @(negedge clk);
        chk("rst_stall_per_vld", {28'b0, per_vld}, 32'h2);
        tick();
        #1 rst = 1'b0;
        sub_vld = 1'b0;
        #1;
        chk("arst_per_vld", {28'b0, per_vld}, 32'h0);
        chk("arst_sub_rdy", {31'b0, sub_rdy}, 32'h0);
        chk("arst_sub_rdt", sub_rdt, 32'h0);
        chk("arst_sub_err", {31'b0, sub_err}, 32'h0);
        chk("arst_err_vld", {31'b0, err_vld}, 32'h0);
        chk("arst_err_tmo", {31'b0, err_tmo}, 32'h0);
        chk("arst_err_adr", err_adr, 32'h0);
        chk("arst_per_adr", per_adr, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("post_rst_per_vld", {28'b0, per_vld}, 32'h0);
        chk("final_queue_empty", sbq.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
